// File: rtl/latch_bank_ctrl.sv
// Bus-side controller for a bank of chip-selected 8-bit latches: one request at a time,
// one-hot cs decode, we/oe sequencing and a held response on a valid/ready port.
module latch_bank_ctrl #(
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned AW        = 2,
    parameter int unsigned RD_WAIT   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [AW-1:0]        req_addr_i,
    input  logic [7:0]           req_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [7:0]           rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic [NUM_BANKS-1:0] cs_o,
    output logic                 we_o,
    output logic                 oe_o,
    output logic [7:0]           di_o,
    input  logic [7:0]           bus_dout_i
);

    typedef enum logic [1:0] {StIdle, StWr, StRd, StRsp} state_e;

    localparam logic [3:0] RdLast = 4'(RD_WAIT);

    state_e                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [7:0]            rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [NUM_BANKS-1:0]  cs_q, cs_d;
    logic                  we_q, we_d;
    logic                  oe_q, oe_d;
    logic [7:0]            di_q, di_d;
    logic [3:0]            cnt_q, cnt_d;

    logic [31:0]           addr_ext;
    logic                  addr_ok;
    logic [NUM_BANKS-1:0]  addr_onehot;

    assign addr_ext = 32'(req_addr_i);
    assign addr_ok  = (addr_ext < NUM_BANKS);

    always_comb begin
        addr_onehot = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            addr_onehot[i] = (addr_ext == i);
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cs_d        = cs_q;
        we_d        = we_q;
        oe_d        = oe_q;
        di_d        = di_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i && req_ready_q) begin
                    req_ready_d = 1'b0;
                    if (!addr_ok) begin
                        // Out-of-range target: answer immediately, never touch the bus.
                        state_d     = StRsp;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 8'h00;
                    end else if (req_write_i) begin
                        state_d = StWr;
                        cs_d    = addr_onehot;
                        we_d    = 1'b1;
                        di_d    = req_wdata_i;
                    end else begin
                        state_d = StRd;
                        cs_d    = addr_onehot;
                        oe_d    = 1'b1;
                        cnt_d   = 4'd0;
                    end
                end
            end
            StWr: begin
                state_d     = StRsp;
                cs_d        = '0;
                we_d        = 1'b0;
                di_d        = 8'h00;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = 8'h00;
            end
            StRd: begin
                if (cnt_q == RdLast) begin
                    state_d     = StRsp;
                    cs_d        = '0;
                    oe_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = bus_dout_i;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StRsp: begin
                if (rsp_ready_i) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = 8'h00;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = StIdle;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = 8'h00;
                cs_d        = '0;
                we_d        = 1'b0;
                oe_d        = 1'b0;
                di_d        = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
            cs_q        <= '0;
            we_q        <= 1'b0;
            oe_q        <= 1'b0;
            di_q        <= 8'h00;
            cnt_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            oe_q        <= oe_d;
            di_q        <= di_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign cs_o        = cs_q;
    assign we_o        = we_q;
    assign oe_o        = oe_q;
    assign di_o        = di_q;

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Bench for latch_bank_ctrl: a 4-bank and a 3-bank instance, each with a behavioural latch bank,
// checked against a transaction-level memory model.
module tb_latch_bank_ctrl;

    localparam int RD_WAIT = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       sel;
    logic       req_valid, req_write, rsp_ready;
    logic [1:0] req_addr;
    logic [7:0] req_wdata;

    logic       rr4, rv4, er4, we4, oe4;
    logic [7:0] rd4, di4, bus4;
    logic [3:0] cs4;
    logic       rr3, rv3, er3, we3, oe3;
    logic [7:0] rd3, di3, bus3;
    logic [2:0] cs3;

    latch_bank_ctrl #(.NUM_BANKS(4), .AW(2), .RD_WAIT(RD_WAIT)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid & ~sel), .req_ready_o(rr4), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rv4), .rsp_ready_i(rsp_ready & ~sel), .rsp_rdata_o(rd4), .rsp_err_o(er4),
        .cs_o(cs4), .we_o(we4), .oe_o(oe4), .di_o(di4), .bus_dout_i(bus4)
    );

    latch_bank_ctrl #(.NUM_BANKS(3), .AW(2), .RD_WAIT(RD_WAIT)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid & sel), .req_ready_o(rr3), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rv3), .rsp_ready_i(rsp_ready & sel), .rsp_rdata_o(rd3), .rsp_err_o(er3),
        .cs_o(cs3), .we_o(we3), .oe_o(oe3), .di_o(di3), .bus_dout_i(bus3)
    );

    logic       o_rr, o_rv, o_er, o_we, o_oe;
    logic [7:0] o_rd, o_di;
    logic [3:0] o_cs;
    assign o_rr = sel ? rr3 : rr4;
    assign o_rv = sel ? rv3 : rv4;
    assign o_er = sel ? er3 : er4;
    assign o_we = sel ? we3 : we4;
    assign o_oe = sel ? oe3 : oe4;
    assign o_rd = sel ? rd3 : rd4;
    assign o_di = sel ? di3 : di4;
    assign o_cs = sel ? {1'b0, cs3} : cs4;

    // Behavioural latch banks on each controller's strobes
    logic [7:0] mem4 [4];
    logic [7:0] mem3 [3];
    logic [7:0] ref_mem [2][4];

    function automatic int idx_of(input logic [3:0] c);
        for (int i = 0; i < 4; i++) if (c[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) if (we4 && $onehot(cs4)) mem4[idx_of(cs4)] <= di4;
    always @(posedge clk) if (we3 && $onehot(cs3)) mem3[idx_of({1'b0, cs3})] <= di3;

    always_comb begin
        bus4 = 8'hzz;
        if (oe4 && $onehot(cs4)) bus4 = mem4[idx_of(cs4)];
    end
    always_comb begin
        bus3 = 8'hzz;
        if (oe3 && $onehot(cs3)) bus3 = mem3[idx_of({1'b0, cs3})];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("invariant4", 32'($onehot0(cs4) && !(we4 && oe4) && (!we4 || $onehot(cs4))
                              && (!oe4 || $onehot(cs4))), 32'd1);
        chk("invariant3", 32'($onehot0(cs3) && !(we3 && oe3) && (!we3 || $onehot(cs3))
                              && (!oe3 || $onehot(cs3))), 32'd1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_cs"}, 32'(o_cs), 32'd0);
        chk({tag, "_we"}, 32'(o_we), 32'd0);
        chk({tag, "_oe"}, 32'(o_oe), 32'd0);
        chk({tag, "_di"}, 32'(o_di), 32'd0);
    endtask

    task automatic do_xact(input bit w, input logic [1:0] a, input logic [7:0] d, input int hold);
        int         n;
        int         nb;
        bit         ok;
        logic [3:0] oh;
        logic [7:0] exp_rd;
        nb = sel ? 3 : 4;
        ok = (int'(a) < nb);
        oh = 4'b0001 << a;
        n = 0;
        while (o_rr !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("req_ready_wait", 32'(o_rr), 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = 1'($urandom);
        step();
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 2'($urandom);
        req_wdata = 8'($urandom);
        chk("busy_req_ready", 32'(o_rr), 32'd0);
        if (ok && w) begin
            chk("wr_cs", 32'(o_cs), 32'(oh));
            chk("wr_we", 32'(o_we), 32'd1);
            chk("wr_oe", 32'(o_oe), 32'd0);
            chk("wr_di", 32'(o_di), 32'(d));
            chk("wr_rsp_early", 32'(o_rv), 32'd0);
            rsp_ready = 1'($urandom);
            step();
        end else if (ok) begin
            for (int k = 0; k <= RD_WAIT; k++) begin
                chk("rd_cs", 32'(o_cs), 32'(oh));
                chk("rd_oe", 32'(o_oe), 32'd1);
                chk("rd_we", 32'(o_we), 32'd0);
                chk("rd_di", 32'(o_di), 32'd0);
                chk("rd_rsp_early", 32'(o_rv), 32'd0);
                rsp_ready = 1'($urandom);
                step();
            end
        end
        rsp_ready = 1'b0;
        exp_rd = (ok && !w) ? ref_mem[sel][a] : 8'h00;
        if (ok && w) ref_mem[sel][a] = d;
        for (int h = 0; h <= hold; h++) begin
            chk("rsp_valid", 32'(o_rv), 32'd1);
            chk("rsp_err", 32'(o_er), 32'(!ok));
            chk("rsp_rdata", 32'(o_rd), 32'(exp_rd));
            chk("rsp_req_ready", 32'(o_rr), 32'd0);
            chk_quiet("rsp");
            if (h < hold) begin
                req_valid = 1'($urandom);
                req_write = 1'($urandom);
                req_addr  = 2'($urandom);
                req_wdata = 8'($urandom);
                step();
            end
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        step();
        rsp_ready = 1'b0;
        chk("post_rsp_valid", 32'(o_rv), 32'd0);
        chk("post_req_ready", 32'(o_rr), 32'd1);
        chk("post_rdata", 32'(o_rd), 32'd0);
        chk_quiet("post");
    endtask

    initial begin
        sel = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = 2'd0;
        req_wdata = 8'h00;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem4[i] = 8'h00;
            ref_mem[0][i] = 8'h00;
            ref_mem[1][i] = 8'h00;
        end
        for (int i = 0; i < 3; i++) mem3[i] = 8'h00;

        #2 rst_n = 1'b0;
        #2;
        chk("reset_rsp_valid", 32'(o_rv), 32'd0);
        chk_quiet("reset");
        #18 rst_n = 1'b1;
        step();
        chk("reset_req_ready", 32'(o_rr), 32'd1);
        chk("reset_rsp_err", 32'(o_er), 32'd0);

        do_xact(1'b1, 2'd2, 8'hA5, 0);
        do_xact(1'b0, 2'd2, 8'h00, 0);
        do_xact(1'b1, 2'd1, 8'h3C, 5);
        do_xact(1'b0, 2'd1, 8'h00, 5);

        // Reset during the first read cycle: strobes drop at once, no response
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 2'd2;
        step();
        req_valid = 1'b0;
        chk("mid_rd_cs", 32'(o_cs), 32'b0100);
        chk("mid_rd_oe", 32'(o_oe), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_rv", 32'(o_rv), 32'd0);
        chk_quiet("async_rst");
        step();
        step();
        #2 rst_n = 1'b1;
        step();
        chk("rst_release_ready", 32'(o_rr), 32'd1);
        chk("rst_release_rv", 32'(o_rv), 32'd0);
        do_xact(1'b0, 2'd2, 8'h00, 1);

        for (int i = 0; i < 4; i++) do_xact(1'b1, 2'(i), 8'(8'h11 * (i + 1)), 0);
        for (int i = 0; i < 4; i++) do_xact(1'b0, 2'(i), 8'h00, 0);

        sel = 1'b1;
        step();
        do_xact(1'b1, 2'd3, 8'h5A, 0);
        do_xact(1'b0, 2'd3, 8'h00, 2);
        do_xact(1'b1, 2'd2, 8'h77, 1);
        do_xact(1'b0, 2'd2, 8'h00, 0);
        for (int i = 0; i < 12; i++) begin
            do_xact(1'($urandom), 2'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        sel = 1'b0;
        step();
        for (int i = 0; i < 30; i++) begin
            do_xact(1'($urandom), 2'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
